// File: rtl/fadd_pkg.sv
// Shared definitions for the fadd arbiter: operand width, default sizing and
// the tag index type carried through the in-flight tag FIFO.
package fadd_pkg;

  localparam int unsigned FADD_DATA_W    = 32;
  localparam int unsigned FADD_N_REQ     = 4;
  localparam int unsigned FADD_TAG_DEPTH = 8;
  // Tag wide enough for up to 256 requesters; unused upper bits stay zero.
  localparam int unsigned FADD_TAG_W     = 8;

  typedef logic [FADD_DATA_W-1:0] fadd_word_t;
  typedef logic [FADD_TAG_W-1:0]  fadd_tag_t;

  // Round-robin successor of idx among n requesters.
  function automatic fadd_tag_t fadd_rr_next(input fadd_tag_t idx, input int unsigned n);
    if (32'(idx) + 32'd1 >= n) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/fadd_tag_fifo.sv
// Synchronous FIFO of requester tags for operations in flight in the fadd.
// Pushes while full and pops while empty are ignored.
module fadd_tag_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/fadd_arbiter.sv
// Round-robin arbiter sharing one in-order fadd unit among N_REQ requesters;
// a tag FIFO remembers the issuing requester so each result is routed back.
module fadd_arbiter
  import fadd_pkg::*;
#(
  parameter int unsigned N_REQ     = FADD_N_REQ,
  parameter int unsigned TAG_DEPTH = FADD_TAG_DEPTH
) (
  input  logic                         S_AXI_ACLK,
  input  logic                         S_AXI_ARESETN,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ*FADD_DATA_W-1:0] req_op1,
  input  logic [N_REQ*FADD_DATA_W-1:0] req_op2,
  output logic [N_REQ-1:0]             resp_valid,
  output logic [FADD_DATA_W-1:0]       resp_data,
  output logic                         fadd_en,
  output logic [FADD_DATA_W-1:0]       fadd_op1,
  output logic [FADD_DATA_W-1:0]       fadd_op2,
  input  logic                         fadd_res_val,
  input  logic [FADD_DATA_W-1:0]       fadd_res,
  output logic                         busy,
  output logic                         err_orphan
);

  localparam int unsigned CNT_W = $clog2(TAG_DEPTH) + 1;

  fadd_tag_t        rr_ptr;
  fadd_tag_t        grant_idx;
  fadd_tag_t        head_tag;
  logic             grant_found;
  logic [N_REQ-1:0] valid_rot;
  logic [N_REQ-1:0] grant_oh;
  logic [N_REQ-1:0] resp_next;
  logic             accept;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] tag_count;
  fadd_word_t       sel_op1;
  fadd_word_t       sel_op2;

  // Rotate so bit 0 is the requester at rr_ptr; first set bit wins.
  assign valid_rot = N_REQ'({req_valid, req_valid} >> rr_ptr);

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = rr_ptr;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!grant_found && valid_rot[i]) begin
        grant_found = 1'b1;
        if (32'(rr_ptr) + i >= N_REQ) begin
          grant_idx = fadd_tag_t'(32'(rr_ptr) + i - N_REQ);
        end else begin
          grant_idx = fadd_tag_t'(32'(rr_ptr) + i);
        end
      end
    end
  end

  always_comb begin
    grant_oh  = '0;
    resp_next = '0;
    sel_op1   = '0;
    sel_op2   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      grant_oh[i]  = grant_found && (grant_idx == fadd_tag_t'(i));
      resp_next[i] = pop && (head_tag == fadd_tag_t'(i));
      if (grant_idx == fadd_tag_t'(i)) begin
        sel_op1 = req_op1[i*FADD_DATA_W +: FADD_DATA_W];
        sel_op2 = req_op2[i*FADD_DATA_W +: FADD_DATA_W];
      end
    end
  end

  // Full blocks issue even when a pop lands in the same cycle.
  assign accept    = S_AXI_ARESETN && grant_found && !fifo_full;
  assign req_ready = accept ? grant_oh : '0;
  assign pop       = fadd_res_val && !fifo_empty;
  assign busy      = (tag_count != '0);

  fadd_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .WIDTH (FADD_TAG_W)
  ) u_tag_fifo (
    .clk   (S_AXI_ACLK),
    .rst_n (S_AXI_ARESETN),
    .push  (accept),
    .pop   (pop),
    .din   (grant_idx),
    .dout  (head_tag),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (tag_count)
  );

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rr_ptr     <= '0;
      fadd_en    <= 1'b0;
      fadd_op1   <= '0;
      fadd_op2   <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
      err_orphan <= 1'b0;
    end else begin
      fadd_en    <= accept;
      resp_valid <= resp_next;
      if (accept) begin
        rr_ptr   <= fadd_rr_next(grant_idx, N_REQ);
        fadd_op1 <= sel_op1;
        fadd_op2 <= sel_op2;
      end
      if (pop) begin
        resp_data <= fadd_res;
      end
      if (fadd_res_val && fifo_empty) begin
        err_orphan <= 1'b1;
      end
    end
  end

endmodule

// File: doc/fadd_arbiter.md
FADD_ARBITER -- requirements
Module: fadd_arbiter

Interface
REQ-001 SHALL provide parameter N_REQ, default 4: number of requesters sharing one fadd unit.
REQ-002 SHALL provide parameter TAG_DEPTH, default 8 (power of 2): maximum number of operations in flight; must be at least fadd latency + 1.
REQ-003 SHALL have port S_AXI_ACLK, input, width 1: the single clock; all logic is rising-edge.
REQ-004 SHALL have port S_AXI_ARESETN, input, width 1: reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, width N_REQ: requester i has an operation pending.
REQ-006 SHALL have port req_ready, output, width N_REQ: one-hot accept; the transfer occurs when valid and ready are both high.
REQ-007 SHALL have ports req_op1 and req_op2, input, width N_REQ*32 each: requester i operands at bits [32i+31:32i].
REQ-008 SHALL have port resp_valid, output, width N_REQ: single-cycle result pulse to the owning requester; there is no backpressure.
REQ-009 SHALL have port resp_data, output, width 32: result, valid when any resp_valid bit is high.
REQ-010 SHALL have ports fadd_en (output, width 1), fadd_op1 (output, width 32) and fadd_op2 (output, width 32): issue to the shared fadd.
REQ-011 SHALL have ports fadd_res_val (input, width 1) and fadd_res (input, width 32): in-order result from the fadd.
REQ-012 SHALL have port busy, output, width 1: high while the tag count is nonzero.
REQ-013 SHALL have port err_orphan, output, width 1: sticky flag, set when a result arrives with no tag outstanding.

Function
REQ-014 SHALL arbitrate round-robin: search starts at rr_ptr and ascends modulo N_REQ; the first requester with valid high is granted.
REQ-015 SHALL drive req_ready combinationally as the grant one-hot when tag count < TAG_DEPTH, and all-zero otherwise.
REQ-016 SHALL set rr_ptr to (granted index + 1) mod N_REQ on each accept, and leave it unchanged when nothing is accepted.
REQ-017 SHALL, on accept at cycle t, drive fadd_en=1 with the registered operands at cycle t+1; fadd_en SHALL be 0 otherwise and the fadd operand outputs SHALL hold their last values.
REQ-018 SHALL push the granted index into the tag FIFO (depth TAG_DEPTH) on accept.
REQ-019 SHALL, on fadd_res_val at cycle t with the FIFO nonempty, pop the head tag and, at t+1, pulse resp_valid[tag]=1 and present resp_data=fadd_res.
REQ-020 SHALL, on fadd_res_val with the FIFO empty, pop nothing, pulse no resp_valid, and set err_orphan until reset.
REQ-021 SHALL handle a simultaneous push and pop: count unchanged, both pointers advance.
REQ-022 SHALL block issue when the FIFO is full, even if a pop occurs in the same cycle; the accept proceeds one cycle later.
REQ-023 SHALL wrap the FIFO pointers modulo TAG_DEPTH; count SHALL be log2(TAG_DEPTH)+1 bits wide.
REQ-024 SHALL return results to each requester in issue order, since the fadd is in-order.

Reset
REQ-025 SHALL, while S_AXI_ARESETN=0, immediately force req_ready=0, fadd_en=0, fadd_op1=0, fadd_op2=0, resp_valid=0, resp_data=0, busy=0, err_orphan=0, rr_ptr=0, FIFO pointers=0 and count=0.
REQ-026 SHALL discard in-flight tags on reset mid-operation; the fadd shares the same reset, so no stale results return.
REQ-027 SHALL accept its first request no earlier than the first rising edge after S_AXI_ARESETN deasserts.

Structure
REQ-028 SHALL take the operand width (32), the default N_REQ and the default TAG_DEPTH from shared package fadd_pkg, which also defines the tag index type.
REQ-029 SHALL instantiate one sub-module, fadd_tag_fifo, a synchronous FIFO with push, pop, full, empty and count, parameterised by depth and width.
REQ-030 SHALL keep the round-robin arbiter inline as combinational logic plus the rr_ptr register.

Verification
REQ-031 SHALL pass single op: requester 2 sends 0x3F800000 + 0x40000000 -> fadd_en at accept+1, then resp_valid[2] with resp_data=0x40400000.
REQ-032 SHALL pass fairness: all 4 requesters hold valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3; each requester gets exactly 2 results, each in order.
REQ-033 SHALL pass full FIFO: a fadd model of latency 10 with TAG_DEPTH=8 -> req_ready drops after 8 accepts, and issue resumes the cycle after the first pop.
REQ-034 SHALL pass orphan: fadd_res_val pulsed with the FIFO empty -> no resp_valid, err_orphan=1 and held until reset.
REQ-035 SHALL pass mid-operation reset: S_AXI_ARESETN asserted with 3 ops outstanding -> all outputs 0 immediately, busy=0, and the next op after release is routed correctly.
REQ-036 SHALL pass simultaneous push and pop at count=5 -> count stays 5 and the pointers wrap correctly across index 7 to 0.
